// File: rtl/decoder_scan.sv
// decoder_scan: registered SEL_W-to-2**SEL_W one-hot decoder with enable
// and an optional self-running scan mode.
//
// Intended to sit between control logic and multiplexed loads such as
// display digit enables or LED/row strobes.
//
// Modes:
//   mode = 0  direct decode of sel
//   mode = 1  scan: a prescaled counter walks the active channel over
//             0..scan_max, advancing once every PRESCALE clocks
//
// Parameters:
//   SEL_W     select width; the output width OUT_W = 2**SEL_W is derived
//   PRESCALE  clocks per scan step (1..2**24-1)
//   PRE_W     prescaler width, 2**PRE_W > PRESCALE
//
// Ports:
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   en        enable; 0 forces the output inactive
//   mode      0 = direct, 1 = scan
//   sel       channel select, used only in direct mode
//   scan_max  highest channel visited in scan mode
//   O         registered one-hot channel output
//   idx       registered index of the active channel
//   step      one-cycle pulse on the cycle idx advances in scan mode
//
// Build option:
//   DECODER_SCAN_ACTIVE_LOW_EN  drive O inverted (active channel low,
//   idle/reset value all ones) for common-anode / active-low loads.
//   The inversion is folded into the output register, so timing and
//   latency are the same in both builds.
//
// FSM: state is IDLE / DIRECT / SCAN. It is held in the internal signal
// 'state' so checkers can bind to it hierarchically.

module decoder_scan #(
  parameter int SEL_W    = 2,
  parameter int PRESCALE = 50000,
  parameter int PRE_W    = 24
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      sel,
  input  logic [SEL_W-1:0]      scan_max,
  output logic [(1<<SEL_W)-1:0] O,
  output logic [SEL_W-1:0]      idx,
  output logic                  step
);

  localparam int OUT_W = 1 << SEL_W;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DIRECT = 2'd1;
  localparam logic [1:0] ST_SCAN   = 2'd2;

  localparam logic [PRE_W-1:0] PRE_TC = PRE_W'(PRESCALE - 1);

`ifdef DECODER_SCAN_ACTIVE_LOW_EN
  localparam logic [OUT_W-1:0] O_MASK = '1;
`else
  localparam logic [OUT_W-1:0] O_MASK = '0;
`endif

  logic [1:0]       state, state_d;
  logic [PRE_W-1:0] pre, pre_d;
  logic [SEL_W-1:0] idx_d;
  logic             step_d;
  logic [OUT_W-1:0] o_d;

  function automatic logic [OUT_W-1:0] onehot(input logic [SEL_W-1:0] ch);
    logic [OUT_W-1:0] r;
    r     = '0;
    r[ch] = 1'b1;
    return r;
  endfunction

  // Priority: en low wins over everything, then mode picks direct/scan.
  always_comb begin
    state_d = state;
    pre_d   = pre;
    idx_d   = idx;
    step_d  = 1'b0;
    if (!en) begin
      state_d = ST_IDLE;
      pre_d   = '0;
      idx_d   = '0;
    end else if (!mode) begin
      state_d = ST_DIRECT;
      pre_d   = '0;
      idx_d   = sel;
    end else if (state != ST_SCAN) begin
      // Entering scan always restarts at channel 0 with a fresh prescaler.
      state_d = ST_SCAN;
      pre_d   = '0;
      idx_d   = '0;
    end else if (pre == PRE_TC) begin
      // scan_max is only sampled here, so lowering it below the current
      // channel wraps straight to 0 on the next step.
      pre_d  = '0;
      idx_d  = (idx >= scan_max) ? '0 : idx + SEL_W'(1);
      step_d = 1'b1;
    end else begin
      pre_d = pre + PRE_W'(1);
    end
    // O is derived from the next idx so O == one-hot(idx) outside IDLE.
    o_d = (state_d == ST_IDLE) ? O_MASK : (onehot(idx_d) ^ O_MASK);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      pre   <= '0;
      idx   <= '0;
      step  <= 1'b0;
      O     <= O_MASK;
    end else begin
      state <= state_d;
      pre   <= pre_d;
      idx   <= idx_d;
      step  <= step_d;
      O     <= o_d;
    end
  end

endmodule
